// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex-to-gfedcba glyph table and the output polarity helper.
package seven_seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high gfedcba glyphs for 0..F (lowercase b and d for 0xB/0xD).
   localparam logic [6:0] HEX_TO_GFEDCBA [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [7:0] SEG_PATTERN_OFF = 8'h00;

   function automatic logic [7:0] seg_polarity(input logic [7:0] pattern, input bit active_low);
      return active_low ? ~pattern : pattern;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational glyph decoder: one hex nibble plus decimal point to an
// active-high {dp,g,f,e,d,c,b,a} pattern.
module hex_to_seg7
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] pattern
);

   logic [6:0] gfedcba;

   always_comb begin
      gfedcba         = HEX_TO_GFEDCBA[nibble];
      pattern         = SEG_PATTERN_OFF;
      pattern[SEG_A]  = gfedcba[0];
      pattern[SEG_B]  = gfedcba[1];
      pattern[SEG_C]  = gfedcba[2];
      pattern[SEG_D]  = gfedcba[3];
      pattern[SEG_E]  = gfedcba[4];
      pattern[SEG_F]  = gfedcba[5];
      pattern[SEG_G]  = gfedcba[6];
      pattern[SEG_DP] = dp;
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with guard interval, blanking,
// leading-zero suppression and a frame-aligned (tear-free) load/commit handshake.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int GUARD          = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit LZ_SUPPRESS    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic                    ready,
   output logic                    frame_tick,
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   anode
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]      DIV_GUARD = DIV_W'(GUARD);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF   = seg_polarity(SEG_PATTERN_OFF, SEG_ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? '1 : '0;

   logic [DIV_W-1:0]        div_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [4*NUM_DIGITS-1:0] shadow_val_reg, disp_val_reg;
   logic [NUM_DIGITS-1:0]   shadow_dp_reg, disp_dp_reg;
   logic [NUM_DIGITS-1:0]   shadow_blank_reg, disp_blank_reg;
   logic                    pending_reg;
   logic                    frame_tick_reg;
   logic [7:0]              segment_reg;
   logic [NUM_DIGITS-1:0]   anode_reg;

   logic                    slot_end, frame_end, slot_lit, zero_run;
   logic [3:0]              digit_nibble [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   an_onehot, dark;
   logic [3:0]              cur_nibble;
   logic                    cur_dp, cur_dark;
   logic [7:0]              cur_pattern, segment_next;
   logic [NUM_DIGITS-1:0]   anode_next;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_nibble[gi] = disp_val_reg[4*gi +: 4];
      assign an_onehot[gi]    = (idx_reg == IDX_W'(gi));
   end

   // Walk from the most significant digit down; a digit stays suppressed only
   // while it and everything above it is a bare zero. Digit 0 always shows.
   always_comb begin
      zero_run = 1'b1;
      dark     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (digit_nibble[i] == 4'h0) && !disp_dp_reg[i];
         dark[i]  = disp_blank_reg[i] || (LZ_SUPPRESS && (i != 0) && zero_run);
      end
   end

   assign cur_nibble = digit_nibble[idx_reg];
   assign cur_dp     = disp_dp_reg[idx_reg];
   assign cur_dark   = dark[idx_reg];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble  (cur_nibble),
      .dp      (cur_dp),
      .pattern (cur_pattern)
   );

   assign slot_end  = (div_reg == DIV_LAST);
   assign frame_end = slot_end && (idx_reg == IDX_LAST);

   always_comb begin
      slot_lit     = enable && (div_reg >= DIV_GUARD);
      segment_next = seg_polarity((slot_lit && !cur_dark) ? cur_pattern : SEG_PATTERN_OFF,
                                  SEG_ACTIVE_LOW);
      anode_next   = slot_lit ? (an_onehot ^ AN_OFF) : AN_OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg          <= '0;
         idx_reg          <= '0;
         shadow_val_reg   <= '0;
         shadow_dp_reg    <= '0;
         shadow_blank_reg <= '0;
         disp_val_reg     <= '0;
         disp_dp_reg      <= '0;
         disp_blank_reg   <= '0;
         pending_reg      <= 1'b0;
         frame_tick_reg   <= 1'b0;
         segment_reg      <= SEG_OFF;
         anode_reg        <= AN_OFF;
      end else begin
         div_reg        <= slot_end ? '0 : div_reg + 1'b1;
         if (slot_end) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
         end
         frame_tick_reg <= frame_end;
         segment_reg    <= segment_next;
         anode_reg      <= anode_next;

         // Commit wins over capture: ready is low on a commit edge, so a
         // coincident load is dropped rather than queued.
         if (frame_end && pending_reg) begin
            disp_val_reg   <= shadow_val_reg;
            disp_dp_reg    <= shadow_dp_reg;
            disp_blank_reg <= shadow_blank_reg;
            pending_reg    <= 1'b0;
         end else if (load && !pending_reg) begin
            shadow_val_reg   <= value;
            shadow_dp_reg    <= dp_in;
            shadow_blank_reg <= blank_in;
            pending_reg      <= 1'b1;
         end
      end
   end

   assign ready      = !pending_reg;
   assign frame_tick = frame_tick_reg;
   assign segment    = segment_reg;
   assign anode      = anode_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, 8-cycle slots,
// guard 2, active-low outputs) against a frame-position reference model.
module tb_seven_seg_scan_driver;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int GUARD = 2;
   localparam int FRAME = N * DIV;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        ready, frame_tick;
   logic [7:0]  segment;
   logic [3:0]  anode;

   int checks = 0;
   int failures = 0;

   seven_seg_scan_driver #(
      .NUM_DIGITS(N), .CLK_DIV(DIV), .GUARD(GUARD),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_in(blank_in), .ready(ready), .frame_tick(frame_tick),
      .segment(segment), .anode(anode)
   );

   always #5 clk = ~clk;

   // Pin pattern a lit digit d should show, straight from the display rules.
   function automatic logic [7:0] digit_pattern(input logic [15:0] v, input logic [3:0] dp,
                                                input logic [3:0] bl, input int d);
      logic [15:0] upper;
      logic [3:0]  upper_dp;
      upper    = v >> (4 * d);
      upper_dp = dp >> d;
      if (bl[d] || (d > 0 && upper == 16'h0 && upper_dp == 4'h0)) return 8'hFF;
      return ~{dp[d], SEG_TBL[upper[3:0]]};
   endfunction

   // Reference model: one frame position counter plus shadow/display copies.
   int          m_pos;
   logic [15:0] m_val, m_sval;
   logic [3:0]  m_dp, m_sdp, m_bl, m_sbl;
   logic        m_pend;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_tick;
   logic        exp_ready;
   assign exp_ready = !m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_pos <= 0; m_val <= '0; m_dp <= '0; m_bl <= '0; m_pend <= 1'b0;
         m_sval <= '0; m_sdp <= '0; m_sbl <= '0;
         exp_seg <= 8'hFF; exp_an <= 4'hF; exp_tick <= 1'b0;
      end else begin
         exp_an   <= (!enable || (m_pos % DIV) < GUARD) ? 4'hF : ~(4'b0001 << (m_pos / DIV));
         exp_seg  <= (!enable || (m_pos % DIV) < GUARD) ? 8'hFF
                     : digit_pattern(m_val, m_dp, m_bl, m_pos / DIV);
         exp_tick <= (m_pos == FRAME - 1);
         m_pos    <= (m_pos + 1) % FRAME;
         if (m_pos == FRAME - 1 && m_pend) begin
            m_val <= m_sval; m_dp <= m_sdp; m_bl <= m_sbl; m_pend <= 1'b0;
         end else if (load && !m_pend) begin
            m_sval <= value; m_sdp <= dp_in; m_sbl <= blank_in; m_pend <= 1'b1;
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1; enable = 1'b1; load = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (segment !== 8'hFF || anode !== 4'hF || ready !== 1'b1 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got seg=%h an=%h rdy=%b tick=%b, required seg=ff an=f rdy=1 tick=0",
                     segment, anode, ready, frame_tick);
         end
      end
      rst = 1'b0;
      for (int j = 0; j < GUARD + 1 + 6; j++) begin
         checks++;
         if (segment !== (j <= GUARD ? 8'hFF : 8'hC0) || anode !== (j <= GUARD ? 4'hF : 4'hE)) begin
            failures++;
            $display("FAIL reset_release cycle %0d got seg=%h an=%h, required seg=%h an=%h",
                     j, segment, anode, (j <= GUARD ? 8'hFF : 8'hC0), (j <= GUARD ? 4'hF : 4'hE));
         end
         @(negedge clk);
      end
      $display("reset sequence done");
   endtask

   task automatic test_basic_load;
      logic [7:0] want [4];
      int ticks;
      want = '{8'h8E, 8'hB0, 8'h08, 8'hF9};
      value = 16'h1A3F; dp_in = 4'b0100; blank_in = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      $display("load value=%h dp=%b blank=%b", 16'h1A3F, 4'b0100, 4'b0000);
      checks++;
      if (ready !== 1'b0) begin
         failures++; $display("FAIL basic_ready_drop got ready=%b, required 0", ready);
      end
      for (int j = 0; j < 2 * FRAME && !exp_tick; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL basic_wait cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
      end
      checks++;
      if (!exp_tick || frame_tick !== 1'b1 || ready !== 1'b1) begin
         failures++; $display("FAIL basic_commit got tick=%b ready=%b, required tick=1 ready=1", frame_tick, ready);
      end
      ticks = 0;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) ticks++;
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL basic_frame cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
         if (j % DIV == 5) begin
            checks++;
            if (segment !== want[j / DIV] || anode !== ~(4'b0001 << (j / DIV))) begin
               failures++;
               $display("FAIL basic_digit%0d got seg=%h an=%h, required seg=%h an=%h", j / DIV,
                        segment, anode, want[j / DIV], ~(4'b0001 << (j / DIV)));
            end
         end
      end
      checks++;
      if (ticks != 1) begin
         failures++; $display("FAIL basic_tick_count got %0d ticks in %0d cycles, required 1", ticks, FRAME);
      end
   endtask

   task automatic test_tear_free;
      for (int j = 0; j < 2 * FRAME && !(m_pos >= DIV && m_pos < 2 * DIV); j++) @(negedge clk);
      value = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'b0000; load = 1'b1;
      $display("mid-frame load value=%h dp=%b at frame position %0d", value, dp_in, m_pos);
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (ready !== 1'b0) begin
         failures++; $display("FAIL tear_ready_drop got ready=%b, required 0", ready);
      end
      for (int j = 0; j < 2 * FRAME && !exp_tick; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL tear_old_frame cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
      end
      checks++;
      if (!exp_tick || ready !== 1'b1 || frame_tick !== 1'b1) begin
         failures++; $display("FAIL tear_commit got ready=%b tick=%b, required ready=1 tick=1", ready, frame_tick);
      end
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL tear_new_frame cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
      end
   endtask

   task automatic test_ignored_load;
      logic [15:0] first_val;
      logic [3:0]  first_dp;
      first_val = 16'($urandom); first_dp = 4'($urandom);
      value = first_val; dp_in = first_dp; blank_in = 4'b0000; load = 1'b1;
      $display("load value=%h dp=%b, then two loads that must be dropped", first_val, first_dp);
      @(negedge clk);
      value = first_val ^ 16'h5A5A; dp_in = ~first_dp;
      @(negedge clk);
      load = 1'b0;
      for (int j = 0; j < 2 * FRAME && m_pos != FRAME - 1; j++) @(negedge clk);
      value = first_val ^ 16'hFFFF; dp_in = 4'b1111; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (ready !== 1'b1 || frame_tick !== 1'b1) begin
         failures++; $display("FAIL ignored_commit_edge got ready=%b tick=%b, required ready=1 tick=1", ready, frame_tick);
      end
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL ignored_frame cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
         if (j == 5) begin
            checks++;
            if (segment !== digit_pattern(first_val, first_dp, 4'b0000, 0)) begin
               failures++;
               $display("FAIL ignored_first_kept got seg=%h, required %h", segment,
                        digit_pattern(first_val, first_dp, 4'b0000, 0));
            end
         end
      end
   endtask

   task automatic test_lz_suppress;
      logic [15:0] vals [2];
      logic [7:0]  want [2][4];
      vals = '{16'h0040, 16'h0000};
      want = '{'{8'hC0, 8'h99, 8'hFF, 8'hFF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
      for (int c = 0; c < 2; c++) begin
         for (int j = 0; j < 2 * FRAME && !exp_ready; j++) @(negedge clk);
         value = vals[c]; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
         $display("lz load value=%h", vals[c]);
         @(negedge clk);
         load = 1'b0;
         for (int j = 0; j < 2 * FRAME && !exp_tick; j++) @(negedge clk);
         for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            if (j % DIV == 5) begin
               checks++;
               if (segment !== want[c][j / DIV] || anode !== ~(4'b0001 << (j / DIV))) begin
                  failures++;
                  $display("FAIL lz_%h_digit%0d got seg=%h an=%h, required seg=%h an=%h", vals[c], j / DIV,
                           segment, anode, want[c][j / DIV], ~(4'b0001 << (j / DIV)));
               end
            end
         end
      end
   endtask

   task automatic test_random;
      for (int j = 0; j < 12 * FRAME; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL random cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
         enable   = ($urandom_range(0, 7) != 0);
         load     = ($urandom_range(0, 5) == 0);
         value    = 16'($urandom) >> $urandom_range(0, 16);
         dp_in    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
         blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         if (load && exp_ready)
            $display("random load value=%h dp=%b blank=%b enable=%b", value, dp_in, blank_in, enable);
      end
      enable = 1'b1; load = 1'b0;
   endtask

   task automatic test_enable_reset;
      int ticks;
      enable = 1'b0;
      @(negedge clk);
      ticks = 0;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) ticks++;
         checks++;
         if (anode !== 4'hF || segment !== 8'hFF) begin
            failures++; $display("FAIL enable_low cycle %0d got seg=%h an=%h, required seg=ff an=f", j, segment, anode);
         end
      end
      checks++;
      if (ticks != 1) begin
         failures++; $display("FAIL enable_low_ticks got %0d, required 1", ticks);
      end
      enable = 1'b1;
      for (int j = 0; j < 2 * FRAME && !exp_ready; j++) @(negedge clk);
      value = 16'h8421; dp_in = 4'b1111; blank_in = 4'b0000; load = 1'b1;
      $display("load value=8421 then reset before commit");
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (ready !== 1'b0) begin
         failures++; $display("FAIL reset_pending_setup got ready=%b, required 0", ready);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (ready !== 1'b1) begin
         failures++; $display("FAIL reset_discard_ready got ready=%b, required 1", ready);
      end
      for (int j = 1; j <= FRAME + 2; j++) begin
         @(negedge clk);
         checks++;
         if ({ready, frame_tick, segment, anode} !== {exp_ready, exp_tick, exp_seg, exp_an}) begin
            failures++;
            $display("FAIL reset_frame cycle %0d got rdy=%b tick=%b seg=%h an=%h, required rdy=%b tick=%b seg=%h an=%h",
                     j, ready, frame_tick, segment, anode, exp_ready, exp_tick, exp_seg, exp_an);
         end
         if (j == 5 || j == 13) begin
            checks++;
            if (segment !== (j == 5 ? 8'hC0 : 8'hFF)) begin
               failures++;
               $display("FAIL reset_display_zero cycle %0d got seg=%h, required %h", j, segment, (j == 5 ? 8'hC0 : 8'hFF));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_tear_free();
      test_ignored_load();
      test_lz_suppress();
      test_random();
      test_enable_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
